// File: rtl/ucsbece154b_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects,
// FSM states and the per-cycle pipeline control bundle.
package ucsbece154b_hazard_ctrl_pkg;

    localparam logic [1:0] forward_ex  = 2'b00;
    localparam logic [1:0] forward_wb  = 2'b01;
    localparam logic [1:0] forward_mem = 2'b10;

    typedef enum logic {
        S_RUN     = 1'b0,
        S_MEMWAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       stall_f;
        logic       stall_d;
        logic       stall_e;
        logic       stall_m;
        logic       flush_d;
        logic       flush_e;
        logic       flush_w;
        logic       redirect;
        logic       recover_sel;
    } ctrl_t;

    // Memory-stage result is younger than Writeback, so it wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs))
            return forward_mem;
        else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
            return forward_wb;
        else
            return forward_ex;
    endfunction

endpackage

// File: rtl/ucsbece154b_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: pipeline register numbers,
// branch resolution, memory handshake and the returned controls.
interface ucsbece154b_hazard_ctrl_if;

    logic [4:0] Rs1D_i;
    logic [4:0] Rs2D_i;
    logic [4:0] Rs1E_i;
    logic [4:0] Rs2E_i;
    logic [4:0] RdE_i;
    logic [4:0] RdM_i;
    logic [4:0] RdW_i;
    logic       RegWriteM_i;
    logic       RegWriteW_i;
    logic       LoadE_i;
    logic       BranchE_i;
    logic       JumpE_i;
    logic       PCSrcE_i;
    logic       BranchTakenE_i;
    logic       TargetMatchE_i;
    logic       MemReqM_i;
    logic       MemReadyM_i;
    logic       ValidW_i;
    logic       CounterClear_i;

    logic [1:0] ForwardAE_o;
    logic [1:0] ForwardBE_o;
    logic       StallF_o;
    logic       StallD_o;
    logic       StallE_o;
    logic       StallM_o;
    logic       FlushD_o;
    logic       FlushE_o;
    logic       FlushW_o;
    logic       RedirectE_o;
    logic       RecoverSelE_o;

    modport master (
        output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
        output RegWriteM_i, RegWriteW_i, LoadE_i,
        output BranchE_i, JumpE_i, PCSrcE_i,
        output BranchTakenE_i, TargetMatchE_i,
        output MemReqM_i, MemReadyM_i, ValidW_i, CounterClear_i,
        input  ForwardAE_o, ForwardBE_o,
        input  StallF_o, StallD_o, StallE_o, StallM_o,
        input  FlushD_o, FlushE_o, FlushW_o,
        input  RedirectE_o, RecoverSelE_o
    );

    modport slave (
        input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
        input  RegWriteM_i, RegWriteW_i, LoadE_i,
        input  BranchE_i, JumpE_i, PCSrcE_i,
        input  BranchTakenE_i, TargetMatchE_i,
        input  MemReqM_i, MemReadyM_i, ValidW_i, CounterClear_i,
        output ForwardAE_o, ForwardBE_o,
        output StallF_o, StallD_o, StallE_o, StallM_o,
        output FlushD_o, FlushE_o, FlushW_o,
        output RedirectE_o, RecoverSelE_o
    );

endinterface

// File: rtl/ucsbece154b_perf_counters.sv
// Cycle / retired / branch / mispredict counters, wrapping, with a
// synchronous clear that beats any increment in the same cycle.
module ucsbece154b_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             instret_en,
    input  logic             branch_en,
    input  logic             mispred_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (clear) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + ONE;
            if (instret_en)
                instret_cnt <= instret_cnt + ONE;
            if (branch_en)
                branch_cnt <= branch_cnt + ONE;
            if (mispred_en)
                mispred_cnt <= mispred_cnt + ONE;
        end
    end

endmodule

// File: rtl/ucsbece154b_hazard_ctrl.sv
// Hazard/recovery controller: forwarding, load-use and mispredict
// recovery, data-memory wait FSM with watchdog, performance counters.
module ucsbece154b_hazard_ctrl
    import ucsbece154b_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    ucsbece154b_hazard_ctrl_if.slave  hz,
    output logic                      MemTimeout_o,
    output logic [CNT_W-1:0]          CycleCnt_o,
    output logic [CNT_W-1:0]          InstretCnt_o,
    output logic [CNT_W-1:0]          BranchCnt_o,
    output logic [CNT_W-1:0]          MispredCnt_o
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nxt;
    logic            to_set;
    logic            mem_stall;
    logic            lu;
    logic            mis;
    logic            mis_act;
    ctrl_t           c;

    // First wait cycle stalls from RUN directly, so no slip.
    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        unique case (state)
            S_RUN: begin
                if (hz.MemReqM_i && !hz.MemReadyM_i) begin
                    state_nxt = S_MEMWAIT;
                    mem_stall = 1'b1;
                end
            end
            S_MEMWAIT: begin
                if (hz.MemReadyM_i)
                    state_nxt = S_RUN;
                else
                    mem_stall = 1'b1;
            end
        endcase
    end

    always_comb begin
        to_cnt_nxt = '0;
        to_set     = 1'b0;
        if (state == S_MEMWAIT && !hz.MemReadyM_i) begin
            if (to_cnt == TO_MAX)
                to_cnt_nxt = to_cnt;
            else
                to_cnt_nxt = to_cnt + TO_W'(1);
            to_set = (to_cnt_nxt == TO_MAX);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_RUN;
            to_cnt       <= '0;
            MemTimeout_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
            if (to_set)
                MemTimeout_o <= 1'b1;
        end
    end

    always_comb begin
        lu = hz.LoadE_i && (hz.RdE_i != 5'd0) &&
             ((hz.RdE_i == hz.Rs1D_i) || (hz.RdE_i == hz.Rs2D_i));
        mis = (hz.BranchE_i || hz.JumpE_i) &&
              ((hz.PCSrcE_i != hz.BranchTakenE_i) ||
               (hz.PCSrcE_i && hz.BranchTakenE_i && !hz.TargetMatchE_i));
        mis_act = mis && !mem_stall;
    end

    // Memory wait freezes everything; a mispredict squashes Decode,
    // which makes any load-use stall on it moot.
    always_comb begin
        c = '0;
        if (!reset) begin
            c.fwd_a = fwd_sel(hz.Rs1E_i, hz.RdM_i, hz.RegWriteM_i,
                              hz.RdW_i, hz.RegWriteW_i);
            c.fwd_b = fwd_sel(hz.Rs2E_i, hz.RdM_i, hz.RegWriteM_i,
                              hz.RdW_i, hz.RegWriteW_i);
            priority case (1'b1)
                mem_stall: begin
                    c.stall_f = 1'b1;
                    c.stall_d = 1'b1;
                    c.stall_e = 1'b1;
                    c.stall_m = 1'b1;
                    c.flush_w = 1'b1;
                end
                mis: begin
                    c.redirect    = 1'b1;
                    c.recover_sel = hz.PCSrcE_i;
                    c.flush_d     = 1'b1;
                    c.flush_e     = 1'b1;
                end
                lu: begin
                    c.stall_f = 1'b1;
                    c.stall_d = 1'b1;
                    c.flush_e = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hz.ForwardAE_o   = c.fwd_a;
    assign hz.ForwardBE_o   = c.fwd_b;
    assign hz.StallF_o      = c.stall_f;
    assign hz.StallD_o      = c.stall_d;
    assign hz.StallE_o      = c.stall_e;
    assign hz.StallM_o      = c.stall_m;
    assign hz.FlushD_o      = c.flush_d;
    assign hz.FlushE_o      = c.flush_e;
    assign hz.FlushW_o      = c.flush_w;
    assign hz.RedirectE_o   = c.redirect;
    assign hz.RecoverSelE_o = c.recover_sel;

    ucsbece154b_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk         (clk),
        .reset       (reset),
        .clear       (hz.CounterClear_i),
        .instret_en  (hz.ValidW_i),
        .branch_en   (hz.BranchE_i && !c.stall_e),
        .mispred_en  (mis_act),
        .cycle_cnt   (CycleCnt_o),
        .instret_cnt (InstretCnt_o),
        .branch_cnt  (BranchCnt_o),
        .mispred_cnt (MispredCnt_o)
    );

endmodule

// File: tb/tb_ucsbece154b_hazard_ctrl.sv
// Directed + randomized bench for the hazard controller, checked
// against a rule-level reference model of the pipeline controls.
module tb_ucsbece154b_hazard_ctrl;

    localparam int CW   = 6;
    localparam int TO   = 4;
    localparam int MASK = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          to_o;
    logic [CW-1:0] cyc_o;
    logic [CW-1:0] ret_o;
    logic [CW-1:0] br_o;
    logic [CW-1:0] mp_o;

    int n_cmp = 0;
    int n_bad = 0;

    bit m_wait;
    int m_wcnt;
    bit m_to;
    int m_cyc, m_ret, m_br, m_mp;

    ucsbece154b_hazard_ctrl_if hz ();

    ucsbece154b_hazard_ctrl #(
        .CNT_W       (CW),
        .MEM_TIMEOUT (TO),
        .TO_W        (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hz           (hz),
        .MemTimeout_o (to_o),
        .CycleCnt_o   (cyc_o),
        .InstretCnt_o (ret_o),
        .BranchCnt_o  (br_o),
        .MispredCnt_o (mp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (hz.RegWriteM_i && hz.RdM_i != 0 && hz.RdM_i == rs) return 2'b10;
        if (hz.RegWriteW_i && hz.RdW_i != 0 && hz.RdW_i == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [12:0] ctrl_obs();
        return {hz.ForwardAE_o, hz.ForwardBE_o,
                hz.StallF_o, hz.StallD_o, hz.StallE_o, hz.StallM_o,
                hz.FlushD_o, hz.FlushE_o, hz.FlushW_o,
                hz.RedirectE_o, hz.RecoverSelE_o};
    endfunction

    task automatic set_idle();
        hz.Rs1D_i = 0; hz.Rs2D_i = 0; hz.Rs1E_i = 0; hz.Rs2E_i = 0;
        hz.RdE_i = 0; hz.RdM_i = 0; hz.RdW_i = 0;
        hz.RegWriteM_i = 0; hz.RegWriteW_i = 0; hz.LoadE_i = 0;
        hz.BranchE_i = 0; hz.JumpE_i = 0; hz.PCSrcE_i = 0;
        hz.BranchTakenE_i = 0; hz.TargetMatchE_i = 0;
        hz.MemReqM_i = 0; hz.MemReadyM_i = 1;
        hz.ValidW_i = 0; hz.CounterClear_i = 0;
    endtask

    task automatic set_random();
        hz.Rs1D_i = 5'($urandom_range(0, 7));
        hz.Rs2D_i = 5'($urandom_range(0, 7));
        hz.Rs1E_i = 5'($urandom_range(0, 7));
        hz.Rs2E_i = 5'($urandom_range(0, 7));
        hz.RdE_i = 5'($urandom_range(0, 7));
        hz.RdM_i = 5'($urandom_range(0, 7));
        hz.RdW_i = 5'($urandom_range(0, 7));
        hz.RegWriteM_i = 1'($urandom);
        hz.RegWriteW_i = 1'($urandom);
        hz.LoadE_i = 1'($urandom);
        hz.BranchE_i = 1'($urandom);
        hz.JumpE_i = ($urandom_range(0, 3) == 0);
        hz.PCSrcE_i = 1'($urandom);
        hz.BranchTakenE_i = 1'($urandom);
        hz.TargetMatchE_i = 1'($urandom);
        hz.MemReqM_i = 1'($urandom);
        hz.MemReadyM_i = ($urandom_range(0, 3) != 0);
        hz.ValidW_i = 1'($urandom);
        hz.CounterClear_i = ($urandom_range(0, 31) == 0);
    endtask

    task automatic model_reset();
        m_wait = 0; m_wcnt = 0; m_to = 0;
        m_cyc = 0; m_ret = 0; m_br = 0; m_mp = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ":cycle"}, cyc_o, m_cyc);
        chk({tag, ":instret"}, ret_o, m_ret);
        chk({tag, ":branch"}, br_o, m_br);
        chk({tag, ":mispred"}, mp_o, m_mp);
        chk({tag, ":timeout"}, to_o, m_to);
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic run_cycle(input string tag);
        bit stl, lu, mis, ma, rdy;
        logic [12:0] e;
        #1;
        rdy = hz.MemReadyM_i;
        stl = !rdy && (m_wait || hz.MemReqM_i);
        lu = hz.LoadE_i && hz.RdE_i != 0 &&
             (hz.RdE_i == hz.Rs1D_i || hz.RdE_i == hz.Rs2D_i);
        mis = (hz.BranchE_i || hz.JumpE_i) &&
              (hz.PCSrcE_i != hz.BranchTakenE_i ||
               (hz.PCSrcE_i && hz.BranchTakenE_i && !hz.TargetMatchE_i));
        ma = mis && !stl;
        e = {ref_fwd(hz.Rs1E_i), ref_fwd(hz.Rs2E_i),
             stl || (lu && !ma), stl || (lu && !ma), stl, stl,
             ma, ma || (lu && !stl), stl,
             ma, ma && hz.PCSrcE_i};
        chk({tag, ":ctrl"}, ctrl_obs(), e);
        @(posedge clk);
        #1;
        if (hz.CounterClear_i) begin
            m_cyc = 0; m_ret = 0; m_br = 0; m_mp = 0;
        end else begin
            m_cyc = (m_cyc + 1) & MASK;
            m_ret = (m_ret + int'(hz.ValidW_i)) & MASK;
            m_br = (m_br + int'(hz.BranchE_i && !stl)) & MASK;
            m_mp = (m_mp + int'(ma)) & MASK;
        end
        if (m_wait && !rdy) begin
            m_wcnt++;
            if (m_wcnt >= TO) m_to = 1;
        end else begin
            m_wcnt = 0;
        end
        m_wait = stl;
        chk_regs(tag);
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        hz.LoadE_i = 1; hz.RdE_i = 6; hz.Rs1D_i = 6;
        hz.RegWriteM_i = 1; hz.RdM_i = 3; hz.Rs1E_i = 3;
        hz.MemReqM_i = 1; hz.MemReadyM_i = 0;
        reset = 1;
        model_reset();
        #2;
        chk("reset:ctrl", ctrl_obs(), 13'd0);
        chk_regs("reset");
        @(negedge clk);
        reset = 0;
        set_idle();
        run_cycle("idle");

        hz.RegWriteM_i = 1; hz.RdM_i = 5; hz.Rs1E_i = 5;
        hz.RegWriteW_i = 1; hz.RdW_i = 5; hz.Rs2E_i = 5;
        #1 chk("fwdA_mem", hz.ForwardAE_o, 2'b10);
        run_cycle("fwd_mem");
        hz.RdM_i = 0; hz.Rs1E_i = 0;
        #1 chk("fwdA_x0", hz.ForwardAE_o, 2'b00);
        run_cycle("fwd_x0");

        set_idle();
        hz.LoadE_i = 1; hz.RdE_i = 6; hz.Rs2D_i = 6;
        #1 chk("lu_stallF", hz.StallF_o, 1'b1);
        run_cycle("loaduse");
        set_idle();
        run_cycle("loaduse_after");

        hz.BranchE_i = 1; hz.BranchTakenE_i = 0; hz.PCSrcE_i = 1;
        #1 chk("mis_redirect", hz.RedirectE_o, 1'b1);
        run_cycle("mispred");
        chk("mis_cnt", mp_o, 1);
        chk("br_cnt", br_o, 1);
        hz.BranchTakenE_i = 1; hz.TargetMatchE_i = 1;
        run_cycle("pred_ok");
        hz.TargetMatchE_i = 0;
        run_cycle("pred_badtgt");
        hz.BranchE_i = 0; hz.JumpE_i = 1; hz.PCSrcE_i = 1;
        hz.BranchTakenE_i = 0; hz.LoadE_i = 1; hz.RdE_i = 2;
        hz.Rs1D_i = 2;
        run_cycle("jump_over_lu");

        set_idle();
        hz.MemReqM_i = 1; hz.MemReadyM_i = 0;
        hz.BranchE_i = 1; hz.PCSrcE_i = 1; hz.BranchTakenE_i = 0;
        for (int i = 0; i < 3; i++) begin
            run_cycle("memwait");
        end
        hz.MemReadyM_i = 1;
        #1 chk("mem_release_redirect", hz.RedirectE_o, 1'b1);
        run_cycle("mem_release");
        set_idle();
        run_cycle("mem_run");

        for (int i = 0; i < 400; i++) begin
            set_random();
            run_cycle("rand");
        end

        set_idle();
        hz.ValidW_i = 1; hz.CounterClear_i = 1;
        run_cycle("clear");
        chk("instret_clear", ret_o, 0);
        hz.CounterClear_i = 0;
        run_cycle("after_clear");

        reset = 1;
        model_reset();
        #1;
        @(negedge clk);
        reset = 0;
        set_idle();
        hz.MemReqM_i = 1; hz.MemReadyM_i = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle("timeout");
        end
        chk("timeout_set", to_o, 1'b1);
        hz.MemReadyM_i = 1;
        run_cycle("timeout_ready");
        set_idle();
        run_cycle("timeout_sticky");

        hz.MemReqM_i = 1; hz.MemReadyM_i = 0;
        run_cycle("pre_async");
        #2 reset = 1;
        #1;
        model_reset();
        chk("async:ctrl", ctrl_obs(), 13'd0);
        chk_regs("async");
        @(negedge clk);
        reset = 0;
        set_idle();
        hz.MemReadyM_i = 0;
        run_cycle("post_async");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
